alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle integer ALU.
- Executes the base RV32I/RV64I ALU ops with a registered result one cycle after accept.
- Executes the RISC-V M-extension ops (MUL*, DIV*, REM*) iteratively over XLEN cycles.
- Sits in EX stage; the pipeline stalls on in_ready low and consumes the result on out_valid/out_ready.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SHW, $clog2(XLEN), shift-amount width taken from input2[SHW-1:0].

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- op  in  5  operation code, see Behaviour.
- input1  in  XLEN  rs1 operand.
- input2  in  XLEN  rs2/immediate operand.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  operation result.
- carryFlag, zeroFlag, overFlowFlag, signFlag  out  1 each  add/sub flags.
- illegal  out  1  op was unsupported; qualified by out_valid.

Behaviour:
- Op codes:
  - 0 ADD, 1 SUB, 2 PASS(input2), 3 OR, 4 AND, 5 XOR, 6 SRL, 7 SRA, 8 SLL, 9 SLT, 10 SLTU.
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Any other code: result 0, flags 0, illegal=1, base-op latency.
- Operands and flags are captured on accept (in_valid & in_ready).
- Flags:
  - Computed from input1 + ~input2 + 1 for SUB/SLT/SLTU, and from input1 + input2 otherwise, on the full XLEN width.
  - carry = carry-out of bit XLEN-1; zero = (sum == 0); sign = sum[XLEN-1].
  - overflow = input1[MSB] ^ (adder's second operand)[MSB] ^ sum[MSB] ^ carry.
  - Flags are registered alongside result.
  - Flags are forced to 0 for M ops.
- SLT = sign != overflow; SLTU = ~carry; both zero-extended.
- Shifts use input2[SHW-1:0] only; SRA is arithmetic.
- FSM states IDLE, MUL, DIV, DONE:
  - IDLE: in_ready=1. On accept:
    - base op -> DONE, result loaded at the same edge.
    - MUL* -> MUL; DIV*/REM* -> DIV; counter = XLEN.
  - MUL: unsigned shift-add on operand magnitudes, one bit per cycle, 2*XLEN accumulator; counter decrements.
    - At counter==1 -> DONE, sign-correcting the 2*XLEN product.
    - MUL selects low XLEN bits; MULH/MULHSU/MULHU select high XLEN bits.
    - MULH: both operands signed. MULHSU: input1 signed, input2 unsigned. MULHU: both unsigned.
  - DIV: restoring division on magnitudes, one quotient bit per cycle; at counter==1 -> DONE with sign correction.
    - Quotient sign = sign1 ^ sign2; remainder sign = sign1 (signed ops only).
  - DONE: out_valid=1.
    - out_ready=0: result, flags and illegal held stable.
    - out_ready=1 with no new accept -> IDLE.
    - in_ready = out_ready, so a back-to-back accept in the same cycle is legal and re-enters MUL/DIV/DONE directly.
- Latency, accept edge to out_valid:
  - base ops: 1 cycle; max throughput 1 op/cycle while out_ready=1.
  - M ops: XLEN+1 cycles; in_ready=0 throughout MUL/DIV.
- Divide boundary cases, no trap:
  - divisor 0: DIV/DIVU quotient = all ones; REM/REMU = input1.
  - signed overflow (most-negative / -1): DIV = most-negative, REM = 0.
  - Both cases still take XLEN+1 cycles; illegal=0.
- Reset values: state IDLE; counter 0; out_valid 0; result 0; all flags 0; illegal 0. in_ready is 1 in the cycle after reset.
- Reset mid MUL/DIV/DONE: operation and result discarded; no out_valid pulse follows.
- in_valid while in_ready=0 is ignored; the requester must hold its request.

Optional Feature:
- Macro ALU_SEQ_MULDIV_EN.
- Defined: M ops behave as above.
- Undefined:
  - MUL and DIV states and datapath are not built.
  - op 16-23 are treated as unsupported: result 0, illegal=1, 1-cycle latency.
  - Base ops are unchanged.

Test Plan:
- XLEN=32, ADD 0xFFFFFFFF + 1 -> 1 cycle later: result 0, carry=1, zero=1, overflow=0; SUB 0x80000000 - 1 -> result 0x7FFFFFFF, overflow=1.
- SLT -1,1 -> 1; SLTU -1,1 -> 0; SRA 0x80000000 by input2=0x21 -> shamt 1, result 0xC0000000.
- MULH 0x80000000 * 0x80000000 -> 0x40000000 after 33 cycles, in_ready=0 for the intervening cycles; MULHSU -1 * 2 -> 0xFFFFFFFF; MUL -3*7 -> 0xFFFFFFEB.
- DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
- Back-to-back ADD stream with out_ready=1 -> one result per cycle; out_ready held 0 for 3 cycles -> result stable and in_ready=0; op=31 -> illegal=1, result 0.
- rst asserted at cycle 10 of a DIVU -> out_valid stays 0 and in_ready=1 next cycle; rerun DIVU 100/7 -> result 14. With macro undefined, MUL -> illegal=1 after 1 cycle.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked integer ALU; M-extension ops built only with ALU_SEQ_MULDIV_EN
// Base ops register their result one cycle after accept; MUL*/DIV*/REM* iterate one bit per cycle.
module alu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] input1,
  input  logic [XLEN-1:0] input2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            carryFlag,
  output logic            zeroFlag,
  output logic            overFlowFlag,
  output logic            signFlag,
  output logic            illegal
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_PASS = 5'd2, OP_OR = 5'd3,
    OP_AND = 5'd4, OP_XOR = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7, OP_SLL = 5'd8,
    OP_SLT = 5'd9, OP_SLTU = 5'd10;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              out_valid_q, illegal_q;
  logic              carry_q, zero_q, ovf_q, sign_q;
  logic [XLEN-1:0]   result_q;

  logic              accept, sub_sel, add_c, add_v, base_ok;
  logic [XLEN-1:0]   add_b, sum, base_res;
  logic [SHW-1:0]    shamt;

  assign in_ready     = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept       = in_valid && in_ready;
  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign carryFlag    = carry_q;
  assign zeroFlag     = zero_q;
  assign overFlowFlag = ovf_q;
  assign signFlag     = sign_q;
  assign illegal      = illegal_q;

  always_comb begin
    sub_sel = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    add_b   = sub_sel ? ~input2 : input2;
    {add_c, sum} = {1'b0, input1} + {1'b0, add_b} + {{XLEN{1'b0}}, sub_sel};
    add_v   = input1[XLEN-1] ^ add_b[XLEN-1] ^ sum[XLEN-1] ^ add_c;
    shamt   = input2[SHW-1:0];
    base_ok = 1'b1;
    case (op)
      OP_ADD, OP_SUB: base_res = sum;
      OP_PASS:        base_res = input2;
      OP_OR:          base_res = input1 | input2;
      OP_AND:         base_res = input1 & input2;
      OP_XOR:         base_res = input1 ^ input2;
      OP_SRL:         base_res = input1 >> shamt;
      OP_SRA:         base_res = $signed(input1) >>> shamt;
      OP_SLL:         base_res = input1 << shamt;
      OP_SLT:         base_res = {{(XLEN-1){1'b0}}, sum[XLEN-1] ^ add_v};
      OP_SLTU:        base_res = {{(XLEN-1){1'b0}}, ~add_c};
      default: begin
        base_res = '0;
        base_ok  = 1'b0;
      end
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18,
    OP_MULHU = 5'd19, OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22;

  // prod_q holds {acc_hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [2*XLEN-1:0] prod_q, step_prod, prod_neg;
  logic [XLEN-1:0]   b_q, mag1, mag2, div_tr, quo, rem, m_res;
  logic [XLEN:0]     mul_hi, div_sh;
  logic [4:0]        op_q;
  logic              neg_q, rneg_q, dz_q, is_m, s1, s2, div_ge;

  always_comb begin
    is_m   = (op[4:3] == 2'b10);
    s1     = (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && input1[XLEN-1];
    s2     = (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && input2[XLEN-1];
    mag1   = s1 ? -input1 : input1;
    mag2   = s2 ? -input2 : input2;
    mul_hi = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : '0);
    div_sh = prod_q[2*XLEN-1:XLEN-1];
    div_ge = div_sh >= {1'b0, b_q};
    div_tr = div_sh[XLEN-1:0] - b_q;
    if (state_q == MUL) step_prod = {mul_hi, prod_q[XLEN-1:1]};
    else step_prod = {div_ge ? div_tr : div_sh[XLEN-1:0], prod_q[XLEN-2:0], div_ge};
    prod_neg = neg_q ? -step_prod : step_prod;
    quo      = step_prod[XLEN-1:0];
    rem      = step_prod[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       m_res = prod_neg[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: m_res = prod_neg[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              m_res = dz_q ? '1 : (neg_q ? -quo : quo);
      default:                      m_res = rneg_q ? -rem : rem;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      sign_q      <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      prod_q      <= '0;
      b_q         <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
`ifdef ALU_SEQ_MULDIV_EN
        MUL, DIV: begin
          prod_q <= step_prod;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= m_res;
          end
        end
`endif
        default: begin
          if (accept) begin
`ifdef ALU_SEQ_MULDIV_EN
            if (is_m) begin
              state_q     <= op[2] ? DIV : MUL;
              cnt_q       <= CW'(XLEN);
              out_valid_q <= 1'b0;
              {carry_q, zero_q, ovf_q, sign_q} <= 4'b0000;
              illegal_q   <= 1'b0;
              prod_q      <= op[2] ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
              b_q         <= op[2] ? mag2 : mag1;
              op_q        <= op;
              neg_q       <= s1 ^ s2;
              rneg_q      <= s1;
              dz_q        <= (input2 == '0);
            end else
`endif
            begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= base_res;
              carry_q     <= base_ok && add_c;
              zero_q      <= base_ok && (sum == '0);
              ovf_q       <= base_ok && add_v;
              sign_q      <= base_ok && sum[XLEN-1];
              illegal_q   <= !base_ok;
            end
          end else if (state_q == DONE && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (XLEN=32)
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic        carryFlag, zeroFlag, overFlowFlag, signFlag, illegal;
  logic [4:0]  op;
  logic [31:0] input1, input2, result;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .input1(input1), .input2(input2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carryFlag(carryFlag), .zeroFlag(zeroFlag),
    .overFlowFlag(overFlowFlag), .signFlag(signFlag), .illegal(illegal)
  );

  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; op = o; input1 = a; input2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_m(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] res, output int lat, output bit rdy_low);
    issue(o, a, b);
    lat = 1; rdy_low = 1'b1;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; input1 = '0; input2 = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL rst_result got=%h want=0", result); end
    total++; if ({carryFlag, zeroFlag, overFlowFlag, signFlag, illegal} !== 5'b0)
      begin bad++; $display("FAIL rst_flags got=%b want=00000", {carryFlag, zeroFlag, overFlowFlag, signFlag, illegal}); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_add_sub;
    issue(5'd0, 32'hFFFF_FFFF, 32'h1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", out_valid); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL add_result got=%h want=0", result); end
    total++; if ({carryFlag, zeroFlag, overFlowFlag, signFlag} !== 4'b1100)
      begin bad++; $display("FAIL add_flags czvs got=%b want=1100", {carryFlag, zeroFlag, overFlowFlag, signFlag}); end
    issue(5'd1, 32'h8000_0000, 32'h1);
    total++; if (result !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sub_result got=%h want=7fffffff", result); end
    total++; if ({carryFlag, zeroFlag, overFlowFlag, signFlag} !== 4'b1010)
      begin bad++; $display("FAIL sub_flags czvs got=%b want=1010", {carryFlag, zeroFlag, overFlowFlag, signFlag}); end
  endtask

  task automatic test_compare_shift;
    logic [4:0]  ops [5] = '{5'd9, 5'd10, 5'd7, 5'd8, 5'd6};
    logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'h8000_0000};
    logic [31:0] bs  [5] = '{32'h1, 32'h1, 32'h21, 32'h1F, 32'h4};
    logic [31:0] exp [5] = '{32'h1, 32'h0, 32'hC000_0000, 32'h8000_0000, 32'h0800_0000};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i]);
      total++; if (result !== exp[i] || illegal !== 1'b0)
        begin bad++; $display("FAIL cmpshift%0d op=%0d got=%h ill=%b want=%h", i, ops[i], result, illegal, exp[i]); end
    end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    in_valid = 1'b1; op = 5'd0;
    for (int i = 1; i <= 4; i++) begin
      input1 = i; input2 = i * 10;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || result !== 32'(i * 11))
        begin bad++; $display("FAIL b2b%0d got=%h v=%b want=%h", i, result, out_valid, 32'(i * 11)); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", out_valid); end
  endtask

  task automatic test_stall;
    issue(5'd0, 32'd2, 32'd3);
    out_ready = 1'b0; in_valid = 1'b1; op = 5'd0; input1 = 32'd100; input2 = 32'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready%0d got=%b want=0", i, in_ready); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || result !== 32'd5)
        begin bad++; $display("FAIL stall_hold%0d got=%h v=%b want=5", i, result, out_valid); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (result !== 32'd101) begin bad++; $display("FAIL stall_next got=%h want=65", result); end
  endtask

  task automatic test_illegal;
    issue(5'd31, 32'hFFFF_FFFF, 32'h1);
    total++; if (illegal !== 1'b1 || result !== 32'h0 || out_valid !== 1'b1)
      begin bad++; $display("FAIL ill31 got ill=%b res=%h v=%b want 1/0/1", illegal, result, out_valid); end
    total++; if ({carryFlag, zeroFlag, overFlowFlag, signFlag} !== 4'b0000)
      begin bad++; $display("FAIL ill31_flags got=%b want=0000", {carryFlag, zeroFlag, overFlowFlag, signFlag}); end
    issue(5'd0, 32'h1, 32'h1);
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL ill_clear got=%b want=0", illegal); end
  endtask

  task automatic test_reset_done;
    out_ready = 1'b0;
    issue(5'd0, 32'd7, 32'd8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    total++; if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL rst_done got v=%b res=%h rdy=%b want 0/0/1", out_valid, result, in_ready); end
  endtask

`ifdef ALU_SEQ_MULDIV_EN
  task automatic test_muldiv;
    logic [4:0]  ops [10] = '{5'd17, 5'd18, 5'd16, 5'd20, 5'd22, 5'd21, 5'd23, 5'd20, 5'd22, 5'd19};
    logic [31:0] as  [10] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bs  [10] = '{32'h8000_0000, 32'd2, 32'd7, 32'd2, 32'd2,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [10] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0, 32'hFFFF_FFFE};
    logic [31:0] res;
    int          lat;
    bit          rdy_low;
    for (int i = 0; i < 10; i++) begin
      do_m(ops[i], as[i], bs[i], res, lat, rdy_low);
      total++; if (res !== exp[i] || illegal !== 1'b0)
        begin bad++; $display("FAIL m%0d op=%0d got=%h ill=%b want=%h", i, ops[i], res, illegal, exp[i]); end
      total++; if (lat != 33 || !rdy_low)
        begin bad++; $display("FAIL m%0d_latency got=%0d rdylow=%b want=33/1", i, lat, rdy_low); end
    end
  endtask

  task automatic test_reset_mid_div;
    logic [31:0] res;
    int          lat;
    bit          rdy_low;
    bit          seen = 1'b0;
    issue(5'd21, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL rst_mid got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL rst_mid_pulse got=1 want=0"); end
    do_m(5'd21, 32'd100, 32'd7, res, lat, rdy_low);
    total++; if (res !== 32'd14 || lat != 33)
      begin bad++; $display("FAIL divu_rerun got=%h lat=%0d want=e/33", res, lat); end
  endtask
`else
  task automatic test_no_muldiv;
    logic [4:0] ops [3] = '{5'd16, 5'd20, 5'd23};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 32'd3, 32'd7);
      total++; if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'h0)
        begin bad++; $display("FAIL nom%0d op=%0d got v=%b ill=%b res=%h want 1/1/0", i, ops[i], out_valid, illegal, result); end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_add_sub;
    test_compare_shift;
    test_back_to_back;
    test_stall;
    test_illegal;
    test_reset_done;
`ifdef ALU_SEQ_MULDIV_EN
    test_muldiv;
    test_reset_mid_div;
`else
    test_no_muldiv;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
